// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: turns a valid/ready command stream into registered
// load/enable/direction pulses for a 10-bit counter, with a small return stack.
module pc_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk5m,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd,
  input  logic [9:0]     cmd_arg,
  input  logic           halt,
  input  logic           clr_err,
  input  logic [9:0]     pc,
  output logic           pc_load,
  output logic           pc_en,
  output logic           pc_updn,
  output logic [9:0]     pc_data,
  output logic           busy,
  output logic [SPW-1:0] stack_cnt,
  output logic           err_ovf,
  output logic           err_unf
);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_STEP_UP = 3'd1;
  localparam logic [2:0] OP_STEP_DN = 3'd2;
  localparam logic [2:0] OP_JUMP    = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RET     = 3'd5;
  localparam logic [2:0] OP_RUN_UP  = 3'd6;
  localparam logic [2:0] OP_RUN_DN  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t         state_r;
  logic [2:0]     op_r;
  logic [9:0]     rem_r;
  logic [9:0]     stack_r [DEPTH];
  logic [SPW-1:0] stack_cnt_r;
  logic           pc_load_r;
  logic           pc_en_r;
  logic           pc_updn_r;
  logic [9:0]     pc_data_r;
  logic           err_ovf_r;
  logic           err_unf_r;

  logic           accept_s;
  logic           full_s;
  logic           empty_s;
  logic           issue_s;
  logic           push_s;
  logic           pop_s;
  logic           ovf_s;
  logic           unf_s;
  logic [9:0]     top_s;
  logic [9:0]     ret_addr_s;

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign pc_load   = pc_load_r;
  assign pc_en     = pc_en_r;
  assign pc_updn   = pc_updn_r;
  assign pc_data   = pc_data_r;
  assign stack_cnt = stack_cnt_r;
  assign err_ovf   = err_ovf_r;
  assign err_unf   = err_unf_r;

  // Command acceptance and stack status decode
  always_comb begin
    accept_s   = cmd_valid && (state_r == ST_IDLE);
    full_s     = (stack_cnt_r == SPW'(DEPTH));
    empty_s    = (stack_cnt_r == SPW'(0));
    issue_s    = (state_r == ST_ISSUE);
    push_s     = issue_s && (op_r == OP_CALL) && !full_s;
    ovf_s      = issue_s && (op_r == OP_CALL) && full_s;
    pop_s      = issue_s && (op_r == OP_RET) && !empty_s;
    unf_s      = issue_s && (op_r == OP_RET) && empty_s;
    // return address is taken from the counter while ISSUE is driving the load
    ret_addr_s = pc + 10'd1;
  end

  // Top-of-stack read mux
  always_comb begin
    top_s = 10'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stack_cnt_r == SPW'(i + 1)) begin
        top_s = stack_r[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Sequencer FSM with registered counter controls
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= 3'd0;
      rem_r     <= 10'd0;
      pc_load_r <= 1'b0;
      pc_en_r   <= 1'b0;
      pc_updn_r <= 1'b0;
      pc_data_r <= 10'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pc_load_r <= 1'b0;
          pc_en_r   <= 1'b0;
          pc_updn_r <= 1'b0;
          pc_data_r <= 10'd0;
          if (accept_s) begin
            op_r    <= cmd;
            state_r <= ST_ISSUE;
            case (cmd)
              OP_NOP: begin
                pc_en_r <= 1'b0;
              end
              OP_STEP_UP: begin
                pc_en_r <= 1'b1;
              end
              OP_STEP_DN: begin
                pc_en_r   <= 1'b1;
                pc_updn_r <= 1'b1;
              end
              OP_JUMP: begin
                pc_load_r <= 1'b1;
                pc_data_r <= cmd_arg;
              end
              OP_CALL: begin
                if (!full_s) begin
                  pc_load_r <= 1'b1;
                  pc_data_r <= cmd_arg;
                end else begin
                  pc_load_r <= 1'b0;
                end
              end
              OP_RET: begin
                if (!empty_s) begin
                  pc_load_r <= 1'b1;
                  pc_data_r <= top_s;
                end else begin
                  pc_load_r <= 1'b0;
                end
              end
              OP_RUN_UP, OP_RUN_DN: begin
                // a zero-length run degenerates into a one-cycle no-op
                if (cmd_arg != 10'd0) begin
                  state_r   <= ST_RUN;
                  rem_r     <= cmd_arg;
                  pc_en_r   <= 1'b1;
                  pc_updn_r <= (cmd == OP_RUN_DN);
                end else begin
                  pc_en_r <= 1'b0;
                end
              end
              default: begin
                pc_en_r <= 1'b0;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r   <= ST_IDLE;
          pc_load_r <= 1'b0;
          pc_en_r   <= 1'b0;
          pc_updn_r <= 1'b0;
          pc_data_r <= 10'd0;
        end
        ST_RUN: begin
          if (halt || (rem_r == 10'd1)) begin
            state_r   <= ST_IDLE;
            rem_r     <= 10'd0;
            pc_en_r   <= 1'b0;
            pc_updn_r <= 1'b0;
          end else begin
            rem_r <= rem_r - 10'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rem_r     <= 10'd0;
          pc_load_r <= 1'b0;
          pc_en_r   <= 1'b0;
          pc_updn_r <= 1'b0;
          pc_data_r <= 10'd0;
        end
      endcase
    end
  end

  // Return-address stack, updated on the ISSUE->IDLE edge
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      stack_cnt_r <= SPW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= 10'd0;
      end
    end else if (push_s) begin
      stack_cnt_r <= stack_cnt_r + SPW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (stack_cnt_r == SPW'(i)) begin
          stack_r[i] <= ret_addr_s;
        end
      end
    end else if (pop_s) begin
      stack_cnt_r <= stack_cnt_r - SPW'(1);
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      if (ovf_s) begin
        err_ovf_r <= 1'b1;
      end else if (clr_err) begin
        err_ovf_r <= 1'b0;
      end
      if (unf_s) begin
        err_unf_r <= 1'b1;
      end else if (clr_err) begin
        err_unf_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed plan steps plus random commands, checked
// against a command-level model of counter value, return stack and error flags.
module tb_pc_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_STEP_UP = 3'd1;
  localparam logic [2:0] OP_STEP_DN = 3'd2;
  localparam logic [2:0] OP_JUMP    = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RET     = 3'd5;
  localparam logic [2:0] OP_RUN_UP  = 3'd6;
  localparam logic [2:0] OP_RUN_DN  = 3'd7;

  logic           clk5m = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           halt = 1'b0;
  logic           clr_err = 1'b0;
  logic [2:0]     cmd = 3'd0;
  logic [9:0]     cmd_arg = 10'd0;
  logic           cmd_ready, pc_load, pc_en, pc_updn, busy, err_ovf, err_unf;
  logic [9:0]     pc_data, pc, cnt;
  logic [SPW-1:0] stack_cnt;

  int vectors = 0;
  int miscompares = 0;

  int         exp_pc = 0;
  logic [9:0] mstk[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  always #5 clk5m = ~clk5m;

  // the program counter the sequencer drives
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) cnt <= 10'd0;
    else if (pc_load) cnt <= pc_data;
    else if (pc_en) cnt <= pc_updn ? cnt - 10'd1 : cnt + 10'd1;
  end
  assign pc = cnt;

  pc_seq_ctrl #(.DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk5m(clk5m), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_arg(cmd_arg), .halt(halt), .clr_err(clr_err), .pc(pc),
    .pc_load(pc_load), .pc_en(pc_en), .pc_updn(pc_updn), .pc_data(pc_data),
    .busy(busy), .stack_cnt(stack_cnt), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"}, 32'(pc), exp_pc);
    chk({tag, "_stack_cnt"}, 32'(stack_cnt), mstk.size());
    chk({tag, "_err_ovf"}, 32'(err_ovf), 32'(m_ovf));
    chk({tag, "_err_unf"}, 32'(err_unf), 32'(m_unf));
  endtask

  // h: halt during the h-th enabled cycle of a run (0 = never); clr: hold clr_err
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [9:0] arg,
                        input int h, input logic clr);
    int cyc = 0;
    int lds = 0;
    int ens = 0;
    int both = 0;
    int n;
    int exp_ld = 0;
    int exp_en = 0;
    int exp_cyc = 1;
    @(negedge clk5m);
    chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd = op;
    cmd_arg = arg;
    clr_err = clr;
    halt = 1'($urandom_range(0, 1));
    @(posedge clk5m);
    #1;
    cmd_valid = 1'b0;
    cmd = 3'($urandom);
    cmd_arg = 10'($urandom);
    forever begin
      @(negedge clk5m);
      if (cmd_ready) break;
      cyc++;
      chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
      if (pc_load) lds++;
      if (pc_en) ens++;
      if (pc_load && pc_en) both++;
      if (op == OP_RUN_UP || op == OP_RUN_DN) halt = (h != 0) && (ens == h);
      else halt = 1'($urandom_range(0, 1));
      if (cyc > 2000) begin
        chk({tag, "_timeout_ready"}, 32'(cmd_ready), 32'd1);
        break;
      end
    end
    halt = 1'b0;
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    clr_err = 1'b0;

    n = int'(arg);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    case (op)
      OP_STEP_UP: begin exp_en = 1; exp_pc = (exp_pc + 1) % 1024; end
      OP_STEP_DN: begin exp_en = 1; exp_pc = (exp_pc + 1023) % 1024; end
      OP_JUMP:    begin exp_ld = 1; exp_pc = n; end
      OP_CALL: begin
        if (mstk.size() == DEPTH) m_ovf = 1'b1;
        else begin
          mstk.push_back(10'((exp_pc + 1) % 1024));
          exp_ld = 1;
          exp_pc = n;
        end
      end
      OP_RET: begin
        if (mstk.size() == 0) m_unf = 1'b1;
        else begin
          exp_pc = int'(mstk.pop_back());
          exp_ld = 1;
        end
      end
      OP_RUN_UP, OP_RUN_DN: begin
        if (n != 0) begin
          if (h > 0 && h < n) n = h;
          exp_en = n;
          exp_cyc = n;
          if (op == OP_RUN_UP) exp_pc = (exp_pc + n) % 1024;
          else exp_pc = (exp_pc + 1024 - n) % 1024;
        end
      end
      default: ;
    endcase
    chk({tag, "_busy_cycles"}, cyc, exp_cyc);
    chk({tag, "_loads"}, lds, exp_ld);
    chk({tag, "_enables"}, ens, exp_en);
    chk({tag, "_load_and_en"}, both, 0);
    check_model(tag);
  endtask

  initial begin
    logic [2:0] rop;
    logic [9:0] rarg;
    int         rh;

    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(pc_load), 32'd0);
    chk("rst_en", 32'(pc_en), 32'd0);
    chk("rst_updn", 32'(pc_updn), 32'd0);
    chk("rst_data", 32'(pc_data), 32'd0);
    check_model("rst");
    @(negedge clk5m);
    rst_n = 1'b1;

    do_cmd("jump3f0", OP_JUMP, 10'h3F0, 0, 1'b0);
    chk("jump3f0_abs", 32'(pc), 32'h3F0);
    do_cmd("up1", OP_STEP_UP, 10'd0, 0, 1'b0);
    do_cmd("up2", OP_STEP_UP, 10'd0, 0, 1'b0);
    chk("up2_abs", 32'(pc), 32'h3F2);
    do_cmd("dn1", OP_STEP_DN, 10'd0, 0, 1'b0);
    chk("dn1_abs", 32'(pc), 32'h3F1);

    do_cmd("jump010", OP_JUMP, 10'h010, 0, 1'b0);
    do_cmd("call200", OP_CALL, 10'h200, 0, 1'b0);
    chk("call200_abs", 32'(pc), 32'h200);
    do_cmd("ret1", OP_RET, 10'd0, 0, 1'b0);
    chk("ret1_abs", 32'(pc), 32'h011);
    do_cmd("jump3ff", OP_JUMP, 10'h3FF, 0, 1'b0);
    do_cmd("call_wrap", OP_CALL, 10'h200, 0, 1'b0);
    do_cmd("ret_wrap", OP_RET, 10'd0, 0, 1'b0);
    chk("ret_wrap_abs", 32'(pc), 32'h000);

    for (int i = 0; i < 5; i++) do_cmd("nest_call", OP_CALL, 10'(64 * i + 5), 0, 1'b0);
    chk("nest_ovf_abs", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 5; i++) do_cmd("nest_ret", OP_RET, 10'd0, 0, 1'b0);
    chk("nest_unf_abs", 32'(err_unf), 32'd1);
    @(negedge clk5m);
    clr_err = 1'b1;
    @(negedge clk5m);
    clr_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_model("clr");

    do_cmd("jump3fd", OP_JUMP, 10'h3FD, 0, 1'b0);
    do_cmd("run_up5", OP_RUN_UP, 10'd5, 0, 1'b0);
    chk("run_up5_abs", 32'(pc), 32'h002);
    do_cmd("run_dn0", OP_RUN_DN, 10'd0, 0, 1'b0);

    do_cmd("jump200", OP_JUMP, 10'h200, 0, 1'b0);
    do_cmd("run_dn100_halt", OP_RUN_DN, 10'd100, 10, 1'b0);
    chk("halt_abs", 32'(pc), 32'h1F6);

    do_cmd("unf_again", OP_RET, 10'd0, 0, 1'b0);
    do_cmd("call_clr", OP_CALL, 10'h0AA, 0, 1'b1);
    do_cmd("ret_pop", OP_RET, 10'd0, 0, 1'b0);
    do_cmd("unf_with_clr", OP_RET, 10'd0, 0, 1'b1);
    chk("unf_wins_abs", 32'(err_unf), 32'd1);

    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      rarg = (rop == OP_RUN_UP || rop == OP_RUN_DN) ? 10'($urandom_range(0, 12))
                                                     : 10'($urandom_range(0, 1023));
      rh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk5m);
        halt = 1'($urandom_range(0, 1));
      end
      do_cmd("rand", rop, rarg, rh, 1'($urandom_range(0, 7) == 0));
    end

    do_cmd("pre_rst_call", OP_CALL, 10'h123, 0, 1'b0);
    @(negedge clk5m);
    cmd_valid = 1'b1;
    cmd = OP_RUN_UP;
    cmd_arg = 10'd50;
    @(posedge clk5m);
    #1;
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk5m);
    chk("midrun_en", 32'(pc_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(pc_en), 32'd0);
    chk("midrst_load", 32'(pc_load), 32'd0);
    chk("midrst_updn", 32'(pc_updn), 32'd0);
    chk("midrst_stack", 32'(stack_cnt), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk5m);
    rst_n = 1'b1;
    exp_pc = 0;
    mstk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_model("post_rst");
    do_cmd("post_rst_jump", OP_JUMP, 10'h155, 0, 1'b0);
    do_cmd("post_rst_up", OP_STEP_UP, 10'd0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
